// File: rtl/noise_gen_pkg.sv
// noise_gen_pkg: default LFSR seeds, LFSR tap function and pipeline fill length for noise_gen_mc.
package noise_gen_pkg;
  typedef logic [63:0] lfsr_state_t;
  localparam lfsr_state_t NOISE_SEED_DEFAULT [32] = '{
    64'h9E37_79B9_7F4A_7C15, 64'hBF58_476D_1CE4_E5B9, 64'h94D0_49BB_1331_11EB, 64'h2545_F491_4F6C_DD1D,
    64'hD6E8_FEB8_6659_FD93, 64'hA076_1D64_78BD_642F, 64'hE703_7ED1_A0B4_28DB, 64'h8EBC_6AF0_9C88_C6E3,
    64'h5899_65CC_7537_4CC3, 64'h1D8E_4E27_C47D_124F, 64'hC2B2_AE3D_27D4_EB4F, 64'h1656_67B1_9E37_79F9,
    64'h27D4_EB2F_1656_67C5, 64'h85EB_CA77_C2B2_AE63, 64'h6A09_E667_F3BC_C908, 64'hBB67_AE85_84CA_A73B,
    64'h3C6E_F372_FE94_F82B, 64'hA54F_F53A_5F1D_36F1, 64'h510E_527F_ADE6_82D1, 64'h9B05_688C_2B3E_6C1F,
    64'h1F83_D9AB_FB41_BD6B, 64'h5BE0_CD19_137E_2179, 64'hCBBB_9D5D_C105_9ED8, 64'h629A_292A_367C_D507,
    64'h9159_015A_3070_DD17, 64'h152F_ECD8_F70E_5939, 64'h6733_2667_FFC0_0B31, 64'h8EB4_4A87_6858_1511,
    64'hDB0C_2E0D_64F9_8FA7, 64'h47B5_481D_BEFA_4FA4, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3211
  };
  function automatic lfsr_state_t lfsr64_step(input lfsr_state_t s);
    return {s[0] ^ s[1] ^ s[3] ^ s[4], s[63:1]};
  endfunction
  function automatic int fill_len(input int n_src);
    return 2 + $clog2(n_src / 2);
  endfunction
endpackage

// File: rtl/noise_lfsr64.sv
// noise_lfsr64: single reseedable 64-bit LFSR; a zero seed loads 1 so the register never locks up.
module noise_lfsr64
  import noise_gen_pkg::*;
#(
  parameter int          U_W  = 28,
  parameter lfsr_state_t SEED = 64'd1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_i,
  input  logic           we_i,
  input  logic [63:0]    data_i,
  output logic [U_W-1:0] u_o
);
  lfsr_state_t state_q, state_d;
  always_comb state_d = we_i ? ((|data_i) ? data_i : 64'd1) : en_i ? lfsr64_step(state_q) : state_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= SEED;
    else state_q <= state_d;
  assign u_o = state_q[63 -: U_W];
endmodule

// File: rtl/noise_gen_mc.sv
// noise_gen_mc: CLT Gaussian, scaled white and random-walk noise from a bank of reseedable LFSRs.
// Defining NOISE_GEN_LEAK_EN turns the walk accumulator into a leaky integrator.
module noise_gen_mc
  import noise_gen_pkg::*;
#(
  parameter int N_SRC   = 8,
  parameter int U_W     = 28,
  parameter int OUT_W   = 32,
  parameter int ACC_W   = 64,
  parameter int WALK_SH = 21,
  parameter int LEAK_SH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic [4:0]                 white_sh_i,
  input  logic                       seed_we_i,
  input  logic [$clog2(N_SRC)-1:0]   seed_idx_i,
  input  logic [63:0]                seed_data_i,
  input  logic                       acc_clr_i,
  output logic signed [OUT_W-1:0]    gauss_o,
  output logic signed [OUT_W-1:0]    white_o,
  output logic signed [OUT_W-1:0]    walk_o,
  output logic                       out_valid_o
);
  localparam int H   = N_SRC / 2;
  localparam int G_W = U_W + 1 + $clog2(H);
  localparam int L   = fill_len(N_SRC);
  localparam int CW  = $clog2(L + 1);
`ifdef NOISE_GEN_LEAK_EN
  localparam bit LEAK = 1'b1;
`else
  localparam bit LEAK = 1'b0;
`endif
  logic [U_W-1:0]          u [N_SRC];
  logic signed [G_W-1:0]   node_d [1:2*H-1];
  logic signed [G_W-1:0]   node_q [1:2*H-1];
  logic signed [OUT_W-1:0] g_out, gauss_q, white_q;
  logic signed [ACC_W-1:0] g_acc, acc_sum, acc_d, acc_q;
  logic [CW-1:0]           cnt_d, cnt_q;
  genvar k, i;
  for (k = 0; k < N_SRC; k++) begin : g_src
    noise_lfsr64 #(.U_W(U_W), .SEED(NOISE_SEED_DEFAULT[k])) u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en_i),
      .we_i   (seed_we_i && seed_idx_i == ($clog2(N_SRC))'(k)),
      .data_i (seed_data_i),
      .u_o    (u[k])
    );
  end
  // Heap-ordered tree: leaves H..2H-1 are the difference stage, node 1 is G.
  for (i = 1; i < 2 * H; i++) begin : g_node
    if (i >= H) begin : g_leaf
      assign node_d[i] = G_W'(u[2*(i-H)]) - G_W'(u[2*(i-H)+1]);
    end else begin : g_sum
      assign node_d[i] = node_q[2*i] + node_q[2*i+1];
    end
  end
  always_comb begin
    g_out   = OUT_W'(node_q[1]);
    g_acc   = ACC_W'(node_q[1]);
    acc_sum = acc_q + g_acc - (LEAK ? (acc_q >>> LEAK_SH) : ACC_W'(0));
    // From count L-1 on, the G stage holds data computed after the last reseed.
    acc_d   = acc_clr_i ? ACC_W'(0) : (en_i && cnt_q >= CW'(L - 1)) ? acc_sum : acc_q;
    cnt_d   = seed_we_i ? '0 : (en_i && cnt_q != CW'(L)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      node_q  <= '{default: '0};
      gauss_q <= '0;
      white_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (en_i) begin
        node_q  <= node_d;
        gauss_q <= g_out;
        white_q <= g_out >>> white_sh_i;
      end
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  assign gauss_o     = gauss_q;
  assign white_o     = white_q;
  assign walk_o      = OUT_W'(acc_q >>> WALK_SH);
  assign out_valid_o = cnt_q == CW'(L);
endmodule
